// File: rtl/lc3b_mem_arbiter.sv
// Two-port (fetch A, data B) arbiter onto one physical memory port.
// Define LC3B_ARB_ROUND_ROBIN_EN for round-robin conflict resolution.
module lc3b_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_a,
  input  logic [15:0] mem_address_a,
  output logic [15:0] mem_rdata_a,
  output logic        mem_resp_a,
  input  logic        mem_read_b,
  input  logic        mem_write_b,
  input  logic [1:0]  mem_byte_enable_b,
  input  logic [15:0] mem_address_b,
  input  logic [15:0] mem_wdata_b,
  output logic [15:0] mem_rdata_b,
  output logic        mem_resp_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_byte_enable,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef logic [15:0] lc3b_word;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t   state_q, state_d;
  logic     req_a, req_b, pick_b, grant;
  logic     gnt_b_q, wr_q;
  logic [1:0] be_q;
  lc3b_word addr_q, wdata_q;
  lc3b_word rdata_a_q, rdata_b_q;

  assign req_a = mem_read_a;
  assign req_b = mem_read_b | mem_write_b;

`ifdef LC3B_ARB_ROUND_ROBIN_EN
  logic b_next_q;

  assign pick_b = req_b & (~req_a | b_next_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      b_next_q <= 1'b1;
    else if (grant)
      b_next_q <= ~pick_b;
  end
`else
  assign pick_b = req_b;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a | req_b) begin
          grant   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp)
          state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured at grant so the physical port ignores requester changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_b_q   <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      if (grant) begin
        gnt_b_q <= pick_b;
        wr_q    <= pick_b & mem_write_b;
        addr_q  <= pick_b ? mem_address_b : mem_address_a;
        wdata_q <= pick_b ? mem_wdata_b : '0;
        be_q    <= (pick_b & mem_write_b) ? mem_byte_enable_b : 2'b11;
      end
      if (state_q == BUSY && pmem_resp) begin
        if (gnt_b_q)
          rdata_b_q <= pmem_rdata;
        else
          rdata_a_q <= pmem_rdata;
      end
    end
  end

  assign pmem_read        = (state_q == BUSY) & ~wr_q;
  assign pmem_write       = (state_q == BUSY) & wr_q;
  assign pmem_byte_enable = be_q;
  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;

  assign mem_resp_a  = (state_q == RESP) & ~gnt_b_q;
  assign mem_resp_b  = (state_q == RESP) & gnt_b_q;
  assign mem_rdata_a = rdata_a_q;
  assign mem_rdata_b = rdata_b_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Bench for lc3b_mem_arbiter: transaction-level model plus
// directed literal checks and randomized traffic.
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_a;
  logic [15:0] mem_address_a;
  logic [15:0] mem_rdata_a;
  logic        mem_resp_a;
  logic        mem_read_b;
  logic        mem_write_b;
  logic [1:0]  mem_byte_enable_b;
  logic [15:0] mem_address_b;
  logic [15:0] mem_wdata_b;
  logic [15:0] mem_rdata_b;
  logic        mem_resp_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  always #5 clk = ~clk;

  lc3b_mem_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read_a        (mem_read_a),
    .mem_address_a     (mem_address_a),
    .mem_rdata_a       (mem_rdata_a),
    .mem_resp_a        (mem_resp_a),
    .mem_read_b        (mem_read_b),
    .mem_write_b       (mem_write_b),
    .mem_byte_enable_b (mem_byte_enable_b),
    .mem_address_b     (mem_address_b),
    .mem_wdata_b       (mem_wdata_b),
    .mem_rdata_b       (mem_rdata_b),
    .mem_resp_b        (mem_resp_b),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_byte_enable  (pmem_byte_enable),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
  );

`ifdef LC3B_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one transaction in flight, then a one-cycle
  // response slot, then requests are looked at again.
  bit         m_busy, m_pb, m_wr, m_ra, m_rb, m_bnext;
  logic [15:0] m_addr, m_wdata, m_rd_a, m_rd_b;
  logic [1:0]  m_be;
  logic        want_a, want_b, take_b;

  assign want_a = mem_read_a;
  assign want_b = mem_read_b | mem_write_b;
  assign take_b = want_b && (!want_a || !RR || m_bnext);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_pb <= 0; m_wr <= 0; m_ra <= 0; m_rb <= 0;
      m_bnext <= 1;
      m_addr <= '0; m_wdata <= '0; m_be <= '0;
      m_rd_a <= '0; m_rd_b <= '0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        m_busy <= 0;
        if (m_pb) begin m_rd_b <= pmem_rdata; m_rb <= 1; end
        else begin m_rd_a <= pmem_rdata; m_ra <= 1; end
      end
    end else if (m_ra || m_rb) begin
      m_ra <= 0;
      m_rb <= 0;
    end else if (want_a || want_b) begin
      m_busy  <= 1;
      m_pb    <= take_b;
      m_wr    <= take_b && mem_write_b;
      m_addr  <= take_b ? mem_address_b : mem_address_a;
      m_wdata <= mem_wdata_b;
      m_be    <= (take_b && mem_write_b) ? mem_byte_enable_b : 2'b11;
      m_bnext <= !take_b;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("resp_a", {15'b0, mem_resp_a}, {15'b0, m_ra});
      chk("resp_b", {15'b0, mem_resp_b}, {15'b0, m_rb});
      chk("rdata_a", mem_rdata_a, m_rd_a);
      chk("rdata_b", mem_rdata_b, m_rd_b);
      chk("pmem_read", {15'b0, pmem_read}, {15'b0, m_busy && !m_wr});
      chk("pmem_write", {15'b0, pmem_write}, {15'b0, m_busy && m_wr});
      if (m_busy) begin
        chk("pmem_address", pmem_address, m_addr);
        chk("pmem_be", {14'b0, pmem_byte_enable}, {14'b0, m_be});
        if (m_wr)
          chk("pmem_wdata", pmem_wdata, m_wdata);
      end
      if (reset) begin
        chk("rst_address", pmem_address, 16'h0000);
        chk("rst_be", {14'b0, pmem_byte_enable}, 16'h0000);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    mem_read_a = 0; mem_address_a = '0;
    mem_read_b = 0; mem_write_b = 0; mem_byte_enable_b = '0;
    mem_address_b = '0; mem_wdata_b = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  bit [3:0] got_ord;
  bit [3:0] exp_ord;
  int       n_got;

  initial begin
    quiet();
    reset = 1'b1;
    cyc();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_pmem_read", {15'b0, pmem_read}, 16'h0000);
    chk("rst_rdata_a", mem_rdata_a, 16'h0000);
    cyc();
    reset = 1'b0;

    // A read, zero wait
    mem_read_a = 1; mem_address_a = 16'h0040;
    cyc();
    pmem_resp = 1; pmem_rdata = 16'h1234;
    @(negedge clk);
    chk("t1_read_c1", {15'b0, pmem_read}, 16'h0001);
    chk("t1_addr_c1", pmem_address, 16'h0040);
    chk("t1_resp_c1", {15'b0, mem_resp_a}, 16'h0000);
    cyc();
    pmem_resp = 0; mem_read_a = 0; pmem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("t1_resp_c2", {15'b0, mem_resp_a}, 16'h0001);
    chk("t1_rdata_c2", mem_rdata_a, 16'h1234);
    chk("t1_read_c2", {15'b0, pmem_read}, 16'h0000);
    cyc();
    @(negedge clk);
    chk("t1_resp_c3", {15'b0, mem_resp_a}, 16'h0000);
    cyc();

    // B write, 3 wait cycles, requester changes inputs while busy
    mem_write_b = 1; mem_address_b = 16'h0100;
    mem_wdata_b = 16'hBEEF; mem_byte_enable_b = 2'b10;
    cyc();
    mem_address_b = 16'h0200; mem_wdata_b = 16'h5555;
    mem_byte_enable_b = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      pmem_resp = (i == 4);
      @(negedge clk);
      chk("t2_write", {15'b0, pmem_write}, 16'h0001);
      chk("t2_addr", pmem_address, 16'h0100);
      chk("t2_be", {14'b0, pmem_byte_enable}, 16'h0002);
      chk("t2_wdata", pmem_wdata, 16'hBEEF);
      chk("t2_no_resp_b", {15'b0, mem_resp_b}, 16'h0000);
      cyc();
    end
    pmem_resp = 0; mem_write_b = 0;
    @(negedge clk);
    chk("t2_resp_b", {15'b0, mem_resp_b}, 16'h0001);
    chk("t2_no_resp_a", {15'b0, mem_resp_a}, 16'h0000);
    chk("t2_write_off", {15'b0, pmem_write}, 16'h0000);
    cyc();
    @(negedge clk);
    chk("t2_resp_b_end", {15'b0, mem_resp_b}, 16'h0000);
    cyc();

    // A and B collide
    mem_read_a = 1; mem_address_a = 16'h0040;
    mem_read_b = 1; mem_address_b = 16'h0100;
    pmem_resp = 1; pmem_rdata = 16'h0B0B;
    cyc();
    @(negedge clk);
`ifndef LC3B_ARB_ROUND_ROBIN_EN
    chk("t3_addr_c1", pmem_address, 16'h0100);
`endif
    cyc();
    mem_read_b = 0; pmem_rdata = 16'h0A0A;
    @(negedge clk);
`ifndef LC3B_ARB_ROUND_ROBIN_EN
    chk("t3_resp_b_c2", {15'b0, mem_resp_b}, 16'h0001);
    chk("t3_resp_a_c2", {15'b0, mem_resp_a}, 16'h0000);
    chk("t3_rdata_b_c2", mem_rdata_b, 16'h0B0B);
`endif
    cyc();
    @(negedge clk);
`ifndef LC3B_ARB_ROUND_ROBIN_EN
    chk("t3_dead_c3", {14'b0, mem_resp_a, pmem_read}, 16'h0000);
`endif
    cyc();
    @(negedge clk);
`ifndef LC3B_ARB_ROUND_ROBIN_EN
    chk("t3_addr_c4", pmem_address, 16'h0040);
`endif
    cyc();
    mem_read_a = 0; pmem_resp = 0;
    @(negedge clk);
`ifndef LC3B_ARB_ROUND_ROBIN_EN
    chk("t3_resp_a_c5", {15'b0, mem_resp_a}, 16'h0001);
    chk("t3_rdata_a_c5", mem_rdata_a, 16'h0A0A);
`endif
    cyc();
    quiet();
    repeat (3) cyc();

    // Reset in the second busy cycle, stale pmem_resp afterwards
    mem_read_a = 1; mem_address_a = 16'h0040;
    cyc();
    cyc();
    #1 reset = 1;
    @(negedge clk);
    chk("t6_read_rst", {15'b0, pmem_read}, 16'h0000);
    chk("t6_addr_rst", pmem_address, 16'h0000);
    chk("t6_rdata_a_rst", mem_rdata_a, 16'h0000);
    chk("t6_rdata_b_rst", mem_rdata_b, 16'h0000);
    cyc();
    reset = 0; mem_read_a = 0; pmem_resp = 1; pmem_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_resp", {14'b0, mem_resp_a, mem_resp_b}, 16'h0000);
      cyc();
      pmem_resp = 0;
    end
    mem_read_a = 1; mem_address_a = 16'h0077;
    pmem_rdata = 16'h4321; pmem_resp = 1;
    cyc();
    @(negedge clk);
    chk("t6_addr_new", pmem_address, 16'h0077);
    cyc();
    mem_read_a = 0; pmem_resp = 0;
    @(negedge clk);
    chk("t6_resp_new", {15'b0, mem_resp_a}, 16'h0001);
    chk("t6_rdata_new", mem_rdata_a, 16'h4321);
    cyc();

    // Both ports held for four transactions after reset
    reset = 1;
    cyc();
    reset = 0;
    mem_read_a = 1; mem_address_a = 16'h0011;
    mem_read_b = 1; mem_address_b = 16'h0022;
    pmem_resp = 1;
    n_got = 0;
    got_ord = '0;
    exp_ord = RR ? 4'b0101 : 4'b1111;
    for (int c = 0; c < 40 && n_got < 4; c++) begin
      @(negedge clk);
      if (mem_resp_a || mem_resp_b) begin
        got_ord[n_got] = mem_resp_b;
        n_got++;
      end
      cyc();
    end
    chk("t4_count", 16'(n_got), 16'd4);
    chk("t4_order", {12'b0, got_ord}, {12'b0, exp_ord});
    quiet();
    repeat (3) cyc();

    // Randomized traffic, occasional resets
    for (int c = 0; c < 3000; c++) begin
      mem_read_a        = ($urandom() % 3) != 0;
      mem_address_a     = 16'($urandom());
      mem_read_b        = ($urandom() % 3) == 0;
      mem_write_b       = ($urandom() % 3) == 0;
      mem_byte_enable_b = 2'($urandom());
      mem_address_b     = 16'($urandom());
      mem_wdata_b       = 16'($urandom());
      pmem_resp         = ($urandom() % 3) == 0;
      pmem_rdata        = 16'($urandom());
      reset             = ($urandom() % 400) == 0;
      cyc();
    end
    reset = 0;
    quiet();
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
